sound_freq_sweep: RTL and testbench
===================================

Name: sound_freq_sweep

Overview:
Channel-1 frequency sweep unit, clocked by the 256 Hz length-counter clock. It divides that clock to the 128 Hz sweep rate and periodically adds or subtracts a shifted copy of a shadow frequency. It drives the channel's 11-bit period to the tone generator. It also drives an `enable` that is ANDed with the length counter's `enable` downstream; an overflow silences the channel until the next trigger.

Parameters:
- FREQ_WIDTH, 11, frequency/shadow width; the overflow bit is FREQ_WIDTH.
- PERIOD_WIDTH, 3, sweep period field width.
- SHIFT_WIDTH, 3, sweep shift field width.
- DIV, 2, clk_length_ctr edges per sweep tick.

Ports:
- rst  in  1  asynchronous active-high reset.
- clk_length_ctr  in  1  block clock, 256 Hz length clock.
- start  in  1  channel trigger, synchronous to clk_length_ctr; only its rising edge acts.
- sweep_period  in  PERIOD_WIDTH  sweep timer reload value; 0 means sweep calculation off.
- sweep_negate  in  1  1 = subtract, 0 = add.
- sweep_shift  in  SHIFT_WIDTH  right-shift amount.
- freq_in  in  FREQ_WIDTH  frequency register value, loaded on trigger.
- freq_out  out  FREQ_WIDTH  current channel frequency.
- freq_update  out  1  one-cycle pulse when freq_out is written by a sweep.
- enable  out  1  channel alive; 0 after an overflow.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: rst is asynchronous, active-high, clock is clk_length_ctr. Reset clears enable, freq_out, freq_update, busy, shadow, timer, sweep_en, start_d and the divider phase; state goes to IDLE. Reset asserted mid-operation aborts immediately.
- Divider: phase counts 0..DIV-1 on every edge. A sweep tick occurs on the edge where phase == DIV-1. Start does not reset the phase.
- Trigger detect: trig = start & ~start_d. On a trig edge:
  - shadow <= freq_in; freq_out <= freq_in; enable <= 1.
  - timer <= (sweep_period == 0) ? 8 : sweep_period.
  - sweep_en <= (sweep_period != 0) || (sweep_shift != 0).
  - state <= CHECK if sweep_shift != 0, else IDLE.
  - Trig aborts any in-flight CALC/CHECK and discards a pending event. A tick on the same edge is ignored for the timer.
- Timer: on each tick without trig, if sweep_en:
  - Decrement timer.
  - When it reaches 0, reload with (sweep_period == 0) ? 8 : sweep_period.
  - If sweep_period != 0 at that point, raise a sweep event.
- Arithmetic: calc = negate ? shadow - (shadow >> shift) : shadow + (shadow >> shift). It is computed FREQ_WIDTH+1 bits wide. Subtraction cannot underflow. Overflow = calc[FREQ_WIDTH].
- FSM IDLE -> CALC on a sweep event, one edge of latency.
- CALC:
  - If overflow: enable <= 0, sweep_en <= 0, go to IDLE.
  - Else if shift != 0: shadow <= calc, freq_out <= calc, freq_update = 1 for this cycle, go to CHECK.
  - Else go to IDLE; shift 0 still performs the overflow test.
- CHECK:
  - Recompute from the current shadow.
  - If overflow: enable <= 0, sweep_en <= 0.
  - No writeback.
  - Go to CALC if a sweep event fired on this same edge or is pending, else IDLE.
- Pending event: a sweep event raised while state != IDLE is latched (one deep) and serviced after CHECK.
- After enable = 0: no further ticks act until the next trig. freq_out holds its last value.
- Register inputs (period, negate, shift) are read live at the moment of use. They are not latched at trigger.
- busy = (state != IDLE).

Decomposition:
- Shared package sound_pkg:
  - FREQ_WIDTH localparam.
  - sweep_state_t enum {IDLE, CALC, CHECK}.
  - Function sweep_reload(period) returning 8 for 0.
  - Function sweep_calc(shadow, shift, negate) returning FREQ_WIDTH+1 bits.
- One sub-module: sound_sweep_timer, containing the divider, the period timer and the one-deep pending-event flag. It outputs a sweep_event pulse. The parent holds the trigger detect, the FSM and the datapath.

Test Plan:
- Reset -> freq_out=0, enable=0, busy=0, freq_update=0. Assert rst mid-CALC -> all outputs return to 0 asynchronously.
- Add with overflow: freq_in=0x400, period=1, shift=1, negate=0, pulse start.
  - Edge after trig: CHECK computes 0x600, enable stays 1.
  - First sweep tick: freq_out=0x600 with a 1-cycle freq_update.
  - Following CHECK computes 0x900 -> enable=0; freq_out stays 0x600.
- Negate: freq_in=0x100, period=2, shift=2, negate=1 -> freq_out 0x0C0 after the 2nd tick, 0x090 after the 4th tick, 0x06C after the 6th tick. enable stays 1.
- Shift 0: freq_in=0x7FF, period=3, shift=0 -> no check at trigger, freq_out never changes. At the 3rd tick CALC sees 0xFFE -> enable=0.
- Period 0: freq_in=0x780, period=0, shift=3 -> trigger CHECK computes 0x870 -> enable=0 one edge after trig. Repeat with freq_in=0x100 -> enable stays 1 and freq_out stays 0x100 for 32 edges.
- Retrigger mid-operation:
  - Hold start high for 5 edges -> exactly one trigger.
  - Pulse start on the CALC edge with freq_in=0x200 -> freq_out=0x200, no freq_update, state CHECK (shift != 0).

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants, FSM state type and sweep arithmetic helpers for the
// channel-1 frequency sweep unit.
package sound_pkg;

   localparam int FREQ_WIDTH   = 11;
   localparam int PERIOD_WIDTH = 3;
   localparam int SHIFT_WIDTH  = 3;
   localparam int TIMER_WIDTH  = 4;
   localparam int SWEEP_DIV    = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      CHECK = 2'd2
   } sweep_state_t;

   // A period of 0 still runs the timer, with an effective length of 8.
   function automatic logic [TIMER_WIDTH-1:0] sweep_reload(input logic [PERIOD_WIDTH-1:0] period);
      return (period == '0) ? TIMER_WIDTH'(8) : TIMER_WIDTH'(period);
   endfunction

   function automatic logic [FREQ_WIDTH:0] sweep_calc(
      input logic [FREQ_WIDTH-1:0]  shadow,
      input logic [SHIFT_WIDTH-1:0] shift,
      input logic                   negate
   );
      logic [FREQ_WIDTH:0] w_s;
      logic [FREQ_WIDTH:0] w_d;
      w_s = {1'b0, shadow};
      w_d = w_s >> shift;
      return negate ? (w_s - w_d) : (w_s + w_d);
   endfunction

endpackage

// File: rtl/sound_sweep_timer.sv
// Sweep-rate divider, reloadable period timer and one-deep pending-event flag.
// o_sweep_event is combinational and valid in the cycle before the acting edge.
module sound_sweep_timer
   import sound_pkg::*;
#(
   parameter int DIV = SWEEP_DIV
) (
   input  logic                    clk_length_ctr,
   input  logic                    rst,
   input  logic                    i_trig,
   input  logic                    i_sweep_en,
   input  logic [PERIOD_WIDTH-1:0] i_sweep_period,
   input  logic                    i_idle,
   input  logic                    i_consume,
   output logic                    o_sweep_event,
   output logic                    o_pending
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0]          r_phase;
   logic [TIMER_WIDTH-1:0] r_timer;
   logic                   r_pending;
   logic                   w_tick;
   logic                   w_act;
   logic                   w_expire;

   assign w_tick        = (r_phase == PW'(DIV - 1));
   assign w_act         = w_tick & ~i_trig & i_sweep_en;
   assign w_expire      = w_act & (r_timer <= TIMER_WIDTH'(1));
   assign o_sweep_event = w_expire & (i_sweep_period != '0);
   assign o_pending     = r_pending;

   // The divider free-runs from reset; a trigger never realigns it.
   always_ff @(posedge clk_length_ctr or posedge rst) begin
      if (rst) begin
         r_phase <= '0;
      end else if (w_tick) begin
         r_phase <= '0;
      end else begin
         r_phase <= r_phase + PW'(1);
      end
   end

   always_ff @(posedge clk_length_ctr or posedge rst) begin
      if (rst) begin
         r_timer   <= '0;
         r_pending <= 1'b0;
      end else if (i_trig) begin
         r_timer   <= sweep_reload(i_sweep_period);
         r_pending <= 1'b0;
      end else begin
         if (w_act) begin
            r_timer <= w_expire ? sweep_reload(i_sweep_period) : (r_timer - TIMER_WIDTH'(1));
         end
         if (!i_sweep_en) begin
            r_pending <= 1'b0;
         end else if (i_consume) begin
            r_pending <= r_pending & o_sweep_event;
         end else if (o_sweep_event && !i_idle) begin
            r_pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sound_freq_sweep.sv
// Channel-1 frequency sweep: trigger detect, IDLE/CALC/CHECK FSM and the
// shadow/frequency datapath. o_dbg_state exposes the FSM state.
module sound_freq_sweep
   import sound_pkg::*;
#(
   parameter int DIV = SWEEP_DIV
) (
   input  logic                    rst,
   input  logic                    clk_length_ctr,
   input  logic                    start,
   input  logic [PERIOD_WIDTH-1:0] sweep_period,
   input  logic                    sweep_negate,
   input  logic [SHIFT_WIDTH-1:0]  sweep_shift,
   input  logic [FREQ_WIDTH-1:0]   freq_in,
   output logic [FREQ_WIDTH-1:0]   freq_out,
   output logic                    freq_update,
   output logic                    enable,
   output logic                    busy,
   output logic [1:0]              o_dbg_state
);

   sweep_state_t          r_state;
   logic [FREQ_WIDTH-1:0] r_shadow;
   logic [FREQ_WIDTH-1:0] r_freq;
   logic                  r_update;
   logic                  r_enable;
   logic                  r_sweep_en;
   logic                  r_start_d;

   logic                  w_trig;
   logic [FREQ_WIDTH:0]   w_calc;
   logic                  w_ovf;
   logic                  w_sweep_event;
   logic                  w_pending;
   logic                  w_go;
   logic                  w_consume;

   assign w_trig    = start & ~r_start_d;
   assign w_calc    = sweep_calc(r_shadow, sweep_shift, sweep_negate);
   assign w_ovf     = w_calc[FREQ_WIDTH];
   assign w_go      = w_sweep_event | w_pending;
   // An event is used up when it moves the FSM into CALC.
   assign w_consume = ~w_trig & w_go &
                      ((r_state == IDLE) | ((r_state == CHECK) & ~w_ovf));

   sound_sweep_timer #(.DIV(DIV)) u_timer (
      .clk_length_ctr (clk_length_ctr),
      .rst            (rst),
      .i_trig         (w_trig),
      .i_sweep_en     (r_sweep_en),
      .i_sweep_period (sweep_period),
      .i_idle         (r_state == IDLE),
      .i_consume      (w_consume),
      .o_sweep_event  (w_sweep_event),
      .o_pending      (w_pending)
   );

   always_ff @(posedge clk_length_ctr or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shadow   <= '0;
         r_freq     <= '0;
         r_update   <= 1'b0;
         r_enable   <= 1'b0;
         r_sweep_en <= 1'b0;
         r_start_d  <= 1'b0;
      end else begin
         r_start_d <= start;
         r_update  <= 1'b0;
         if (w_trig) begin
            r_shadow   <= freq_in;
            r_freq     <= freq_in;
            r_enable   <= 1'b1;
            r_sweep_en <= (sweep_period != '0) || (sweep_shift != '0);
            r_state    <= (sweep_shift != '0) ? CHECK : IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_go && r_sweep_en) begin
                     r_state <= CALC;
                  end
               end
               CALC: begin
                  if (w_ovf) begin
                     r_enable   <= 1'b0;
                     r_sweep_en <= 1'b0;
                     r_state    <= IDLE;
                  end else if (sweep_shift != '0) begin
                     r_shadow <= w_calc[FREQ_WIDTH-1:0];
                     r_freq   <= w_calc[FREQ_WIDTH-1:0];
                     r_update <= 1'b1;
                     r_state  <= CHECK;
                  end else begin
                     r_state <= IDLE;
                  end
               end
               CHECK: begin
                  // A dead channel never re-enters CALC, even with an event queued.
                  if (w_ovf) begin
                     r_enable   <= 1'b0;
                     r_sweep_en <= 1'b0;
                     r_state    <= IDLE;
                  end else begin
                     r_state <= w_go ? CALC : IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign freq_out    = r_freq;
   assign freq_update = r_update;
   assign enable      = r_enable;
   assign busy        = (r_state != IDLE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sound_freq_sweep.sv
// Directed bench for sound_freq_sweep: expected sweep writebacks are queued by
// the driver and matched by a monitor on every freq_update pulse.
module tb_sound_freq_sweep;
   import sound_pkg::*;

   logic                    rst;
   logic                    clk_length_ctr;
   logic                    start;
   logic [PERIOD_WIDTH-1:0] sweep_period;
   logic                    sweep_negate;
   logic [SHIFT_WIDTH-1:0]  sweep_shift;
   logic [FREQ_WIDTH-1:0]   freq_in;
   logic [FREQ_WIDTH-1:0]   freq_out;
   logic                    freq_update;
   logic                    enable;
   logic                    busy;
   logic [1:0]              o_dbg_state;

   logic [FREQ_WIDTH-1:0] exp_q[$];
   int checks;
   int errors;
   int n_upd;

   sound_freq_sweep dut (
      .rst            (rst),
      .clk_length_ctr (clk_length_ctr),
      .start          (start),
      .sweep_period   (sweep_period),
      .sweep_negate   (sweep_negate),
      .sweep_shift    (sweep_shift),
      .freq_in        (freq_in),
      .freq_out       (freq_out),
      .freq_update    (freq_update),
      .enable         (enable),
      .busy           (busy),
      .o_dbg_state    (o_dbg_state)
   );

   // Clock and reset.
   initial clk_length_ctr = 1'b0;
   always #5 clk_length_ctr = ~clk_length_ctr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard: every writeback pulse must match the queue head.
   always @(negedge clk_length_ctr) begin
      if (!rst && freq_update) begin
         n_upd++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_update: got freq_out 0x%0h with nothing expected", freq_out);
         end else begin
            logic [FREQ_WIDTH-1:0] e;
            e = exp_q.pop_front();
            if (freq_out !== e) begin
               errors++;
               $display("FAIL update_value: got 0x%0h expected 0x%0h", freq_out, e);
            end
         end
      end
   end

   // Driver tasks: inputs change on the falling edge.
   task automatic edges(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_length_ctr);
   endtask

   task automatic do_reset();
      @(negedge clk_length_ctr);
      rst = 1'b1;
      start = 1'b0;
      edges(2);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic trigger(input logic [FREQ_WIDTH-1:0] f, input logic [PERIOD_WIDTH-1:0] p,
                          input logic [SHIFT_WIDTH-1:0] s, input logic neg);
      @(negedge clk_length_ctr);
      freq_in = f;
      sweep_period = p;
      sweep_shift = s;
      sweep_negate = neg;
      start = 1'b1;
      @(negedge clk_length_ctr);
      start = 1'b0;
   endtask

   task automatic wait_updates(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (n_upd < n && k < budget) begin
         @(negedge clk_length_ctr);
         k++;
      end
      if (n_upd < n) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d updates expected %0d", name, n_upd, n);
      end
   endtask

   task automatic wait_calc(input int budget, input string name);
      int k;
      k = 0;
      while (o_dbg_state != CALC && k < budget) begin
         @(negedge clk_length_ctr);
         k++;
      end
      chk({name, "_reach_calc"}, 32'(o_dbg_state), 32'(CALC));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      n_upd = 0;
      rst = 1'b1;
      start = 1'b0;
      sweep_period = '0;
      sweep_negate = 1'b0;
      sweep_shift = '0;
      freq_in = '0;
      edges(2);
      chk("reset_freq_out", 32'(freq_out), 32'h0);
      chk("reset_enable", 32'(enable), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_update", 32'(freq_update), 32'h0);
      rst = 1'b0;

      // Add with overflow: 0x400 -> 0x600 written, next check sees 0x900.
      exp_q.push_back(11'h600);
      n_upd = 0;
      @(negedge clk_length_ctr);
      freq_in = 11'h400; sweep_period = 3'd1; sweep_shift = 3'd1; sweep_negate = 1'b0;
      start = 1'b1;
      @(negedge clk_length_ctr);
      start = 1'b0;
      chk("add_trig_busy", 32'(busy), 32'h1);
      @(negedge clk_length_ctr);
      chk("add_check_enable", 32'(enable), 32'h1);
      wait_updates(1, 20, "add");
      edges(4);
      chk("add_ovf_enable", 32'(enable), 32'h0);
      chk("add_ovf_freq_hold", 32'(freq_out), 32'h600);
      edges(8);
      chk("add_dead_freq", 32'(freq_out), 32'h600);

      // Negate: three writebacks, then reset asserted while in CALC.
      do_reset();
      n_upd = 0;
      exp_q.push_back(11'h0C0);
      exp_q.push_back(11'h090);
      exp_q.push_back(11'h06C);
      trigger(11'h100, 3'd2, 3'd2, 1'b1);
      wait_updates(3, 60, "neg");
      chk("neg_enable", 32'(enable), 32'h1);
      chk("neg_freq", 32'(freq_out), 32'h06C);
      wait_calc(20, "neg");
      rst = 1'b1;
      #1;
      chk("rst_mid_freq_out", 32'(freq_out), 32'h0);
      chk("rst_mid_enable", 32'(enable), 32'h0);
      chk("rst_mid_busy", 32'(busy), 32'h0);
      chk("rst_mid_update", 32'(freq_update), 32'h0);
      edges(2);
      rst = 1'b0;
      exp_q.delete();

      // Shift 0: no trigger check, third tick's CALC overflows on 0xFFE.
      trigger(11'h7FF, 3'd3, 3'd0, 1'b0);
      chk("sh0_no_check_busy", 32'(busy), 32'h0);
      @(negedge clk_length_ctr);
      chk("sh0_early_enable", 32'(enable), 32'h1);
      edges(12);
      chk("sh0_ovf_enable", 32'(enable), 32'h0);
      chk("sh0_freq_hold", 32'(freq_out), 32'h7FF);

      // Period 0: only the trigger check runs.
      do_reset();
      trigger(11'h780, 3'd0, 3'd3, 1'b0);
      chk("p0_trig_enable", 32'(enable), 32'h1);
      @(negedge clk_length_ctr);
      chk("p0_ovf_enable", 32'(enable), 32'h0);
      trigger(11'h100, 3'd0, 3'd3, 1'b0);
      edges(32);
      chk("p0_alive_enable", 32'(enable), 32'h1);
      chk("p0_alive_freq", 32'(freq_out), 32'h100);

      // Held start triggers once; later freq_in changes are ignored.
      do_reset();
      @(negedge clk_length_ctr);
      freq_in = 11'h100; sweep_period = 3'd0; sweep_shift = 3'd1; sweep_negate = 1'b0;
      start = 1'b1;
      @(negedge clk_length_ctr);
      freq_in = 11'h300;
      edges(4);
      start = 1'b0;
      chk("hold_freq", 32'(freq_out), 32'h100);
      chk("hold_enable", 32'(enable), 32'h1);

      // Retrigger on the CALC edge: reload wins, no writeback pulse.
      do_reset();
      trigger(11'h400, 3'd1, 3'd1, 1'b1);
      wait_calc(20, "retrig");
      start = 1'b1;
      freq_in = 11'h200;
      @(posedge clk_length_ctr);
      #1;
      chk("retrig_freq", 32'(freq_out), 32'h200);
      chk("retrig_update", 32'(freq_update), 32'h0);
      chk("retrig_state", 32'(o_dbg_state), 32'(CHECK));
      rst = 1'b1;
      start = 1'b0;
      edges(2);
      rst = 1'b0;

      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
